// File: rtl/spi_master_txn_ctrl.sv
// SPI master transaction sequencer: one start/done handshake per transfer, CPOL/CPHA sclk
// generation and MSB-first shifting on 1, 2 or 4 MOSI/MISO lanes.
module spi_master_txn_ctrl #(
    parameter int NO_OF_SLAVES = 1,
    parameter int CLK_DIV      = 4,
    parameter int MAX_BITS     = 32,
    localparam int SS_W        = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1,
    localparam int NB_W        = $clog2(MAX_BITS) + 1
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic [SS_W-1:0]         slave_sel,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic [1:0]              lanes,
    input  logic [NB_W-1:0]         num_bits,
    input  logic [MAX_BITS-1:0]     tx_data,
    output logic                    busy,
    output logic                    done,
    output logic [MAX_BITS-1:0]     rx_data,
    output logic                    sclk,
    output logic [NO_OF_SLAVES-1:0] cs,
    output logic                    mosi0,
    output logic                    mosi1,
    output logic                    mosi2,
    output logic                    mosi3,
    input  logic                    miso0,
    input  logic                    miso1,
    input  logic                    miso2,
    input  logic                    miso3
);

    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NU_W = NB_W + 1;
    localparam int RX_W = MAX_BITS + 4;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [31:0]     NSL     = 32'(NO_OF_SLAVES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Lane values for the beat at the top of a left-aligned shift register; lane1 carries the higher bit.
    function automatic logic [3:0] beat_bits(input logic [MAX_BITS-1:0] sr, input logic [1:0] lsh);
        logic [3:0] b;
        case (lsh)
            2'd1:    b = {2'b00, sr[MAX_BITS-1], sr[MAX_BITS-2]};
            2'd2:    b = sr[MAX_BITS-1 -: 4];
            default: b = {3'b000, sr[MAX_BITS-1]};
        endcase
        return b;
    endfunction

    function automatic logic [MAX_BITS-1:0] shift_out(input logic [MAX_BITS-1:0] sr, input logic [1:0] lsh);
        logic [MAX_BITS-1:0] r;
        case (lsh)
            2'd1:    r = {sr[MAX_BITS-3:0], 2'b00};
            2'd2:    r = {sr[MAX_BITS-5:0], 4'b0000};
            default: r = {sr[MAX_BITS-2:0], 1'b0};
        endcase
        return r;
    endfunction

    function automatic logic [RX_W-1:0] shift_in(input logic [RX_W-1:0] sr, input logic [1:0] lsh,
                                                 input logic [3:0] m);
        logic [RX_W-1:0] r;
        case (lsh)
            2'd1:    r = {sr[RX_W-3:0], m[1], m[0]};
            2'd2:    r = {sr[RX_W-5:0], m};
            default: r = {sr[RX_W-2:0], m[0]};
        endcase
        return r;
    endfunction

    logic [2:0]              state_r;
    logic [HC_W-1:0]         half_cnt_r;
    logic [NB_W-1:0]         beat_cnt_r;
    logic [NB_W-1:0]         beat_last_r;
    logic [2:0]              pad_r;
    logic [1:0]              lsh_r;
    logic                    cpol_r;
    logic                    cpha_r;
    logic                    sel_ok_r;
    logic                    phase_r;
    logic [MAX_BITS-1:0]     tx_sr_r;
    logic [RX_W-1:0]         rx_sr_r;
    logic                    busy_r;
    logic                    done_r;
    logic [MAX_BITS-1:0]     rx_data_r;
    logic                    sclk_r;
    logic [NO_OF_SLAVES-1:0] cs_r;
    logic [3:0]              mosi_r;

    logic [NB_W-1:0]         n_eff_s;
    logic [NB_W-1:0]         shamt_s;
    logic [1:0]              lsh_s;
    logic [NU_W-1:0]         n_up_s;
    logic [NU_W-1:0]         beats_s;
    logic [NB_W-1:0]         beat_last_s;
    logic [2:0]              pad_s;
    logic [MAX_BITS-1:0]     tx_align_s;
    logic                    sel_ok_s;
    logic [NO_OF_SLAVES-1:0] cs_sel_s;
    logic [3:0]              miso_s;
    logic [3:0]              beat_s;
    logic [MAX_BITS-1:0]     tx_next_s;
    logic [RX_W-1:0]         rx_next_s;
    logic [MAX_BITS-1:0]     rx_fin_s;
    logic                    half_last_s;

    // Transfer geometry decoded from the request inputs, used only at the accept edge.
    always_comb begin
        if ((num_bits == '0) || (num_bits > NB_W'(MAX_BITS))) begin
            n_eff_s = NB_W'(MAX_BITS);
        end else begin
            n_eff_s = num_bits;
        end
        case (lanes)
            2'b01:   lsh_s = 2'd1;
            2'b10:   lsh_s = 2'd2;
            default: lsh_s = 2'd0;
        endcase
        shamt_s     = NB_W'(MAX_BITS) - n_eff_s;
        n_up_s      = {1'b0, n_eff_s} + ((NU_W'(1) << lsh_s) - NU_W'(1));
        beats_s     = n_up_s >> lsh_s;
        beat_last_s = NB_W'(beats_s - NU_W'(1));
        pad_s       = 3'((beats_s << lsh_s) - {1'b0, n_eff_s});
        tx_align_s  = tx_data << shamt_s;
        if (32'(slave_sel) < NSL) begin
            sel_ok_s = 1'b1;
        end else begin
            sel_ok_s = 1'b0;
        end
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            cs_sel_s[i] = (32'(slave_sel) == 32'(i)) ? 1'b0 : 1'b1;
        end
    end

    // Per-beat data movement; excess bits of a short last beat fall off the bottom of rx_sr_r.
    always_comb begin
        miso_s      = {miso3, miso2, miso1, miso0};
        beat_s      = beat_bits(tx_sr_r, lsh_r);
        tx_next_s   = shift_out(tx_sr_r, lsh_r);
        rx_next_s   = shift_in(rx_sr_r, lsh_r, miso_s);
        rx_fin_s    = MAX_BITS'(rx_sr_r >> pad_r);
        half_last_s = (half_cnt_r == HC_LAST);
    end

    // Transaction FSM with all pin and handshake outputs registered.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_r     <= ST_IDLE;
            half_cnt_r  <= '0;
            beat_cnt_r  <= '0;
            beat_last_r <= '0;
            pad_r       <= 3'd0;
            lsh_r       <= 2'd0;
            cpol_r      <= 1'b0;
            cpha_r      <= 1'b0;
            sel_ok_r    <= 1'b0;
            phase_r     <= 1'b0;
            tx_sr_r     <= '0;
            rx_sr_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rx_data_r   <= '0;
            sclk_r      <= 1'b0;
            cs_r        <= '1;
            mosi_r      <= 4'b0000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r <= cpol;
                    cs_r   <= '1;
                    mosi_r <= 4'b0000;
                    // the done cycle is already IDLE but must not accept a new request
                    if (start && !done_r) begin
                        state_r     <= ST_SETUP;
                        busy_r      <= 1'b1;
                        cs_r        <= cs_sel_s;
                        cpol_r      <= cpol;
                        cpha_r      <= cpha;
                        lsh_r       <= lsh_s;
                        beat_last_r <= beat_last_s;
                        pad_r       <= pad_s;
                        sel_ok_r    <= sel_ok_s;
                        half_cnt_r  <= '0;
                        beat_cnt_r  <= '0;
                        phase_r     <= 1'b0;
                        rx_sr_r     <= '0;
                        if (!cpha) begin
                            mosi_r  <= beat_bits(tx_align_s, lsh_s);
                            tx_sr_r <= shift_out(tx_align_s, lsh_s);
                        end else begin
                            tx_sr_r <= tx_align_s;
                        end
                    end
                end
                ST_SETUP: begin
                    if (half_last_s) begin
                        state_r    <= ST_SHIFT;
                        half_cnt_r <= '0;
                        phase_r    <= 1'b0;
                        sclk_r     <= ~cpol_r;
                        if (!cpha_r) begin
                            rx_sr_r <= rx_next_s;
                        end else begin
                            mosi_r  <= beat_s;
                            tx_sr_r <= tx_next_s;
                        end
                    end else begin
                        half_cnt_r <= half_cnt_r + HC_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (half_last_s) begin
                        half_cnt_r <= '0;
                        if (!phase_r) begin
                            phase_r <= 1'b1;
                            sclk_r  <= cpol_r;
                            if (cpha_r) begin
                                rx_sr_r <= rx_next_s;
                            end else if (beat_cnt_r != beat_last_r) begin
                                mosi_r  <= beat_s;
                                tx_sr_r <= tx_next_s;
                            end else begin
                                mosi_r <= 4'b0000;
                            end
                        end else if (beat_cnt_r == beat_last_r) begin
                            state_r <= ST_HOLD;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + NB_W'(1);
                            phase_r    <= 1'b0;
                            sclk_r     <= ~cpol_r;
                            if (!cpha_r) begin
                                rx_sr_r <= rx_next_s;
                            end else begin
                                mosi_r  <= beat_s;
                                tx_sr_r <= tx_next_s;
                            end
                        end
                    end else begin
                        half_cnt_r <= half_cnt_r + HC_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (half_last_s) begin
                        state_r    <= ST_DONE;
                        half_cnt_r <= '0;
                    end else begin
                        half_cnt_r <= half_cnt_r + HC_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    cs_r      <= '1;
                    mosi_r    <= 4'b0000;
                    sclk_r    <= cpol_r;
                    rx_data_r <= sel_ok_r ? rx_fin_s : '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cs_r    <= '1;
                    mosi_r  <= 4'b0000;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;
    assign sclk    = sclk_r;
    assign cs      = cs_r;
    assign mosi0   = mosi_r[0];
    assign mosi1   = mosi_r[1];
    assign mosi2   = mosi_r[2];
    assign mosi3   = mosi_r[3];

endmodule

// File: tb/tb_spi_master_txn_ctrl.sv
// Self-checking bench for spi_master_txn_ctrl: expected rx/latency pushed on start, popped on done.
module tb_spi_master_txn_ctrl;

    localparam int H = 2;

    typedef struct {
        logic [31:0] rx;
        int          lat;
    } exp_t;

    typedef struct {
        logic        p;
        logic        h;
        logic [1:0]  ln;
        logic [5:0]  nb;
        logic [31:0] tx;
    } mode_t;

    logic        pclk = 1'b0;
    logic        areset;
    logic        start;
    logic [0:0]  slave_sel;
    logic        cpol;
    logic        cpha;
    logic [1:0]  lanes;
    logic [5:0]  num_bits;
    logic [31:0] tx_data;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;
    logic        sclk;
    logic [1:0]  cs;
    logic        mosi0, mosi1, mosi2, mosi3;
    logic        miso0, miso1, miso2, miso3;
    bit          miso_tied;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t sb_q[$];

    assign miso0 = miso_tied ? 1'b1 : mosi0;
    assign miso1 = miso_tied ? 1'b1 : mosi1;
    assign miso2 = miso_tied ? 1'b1 : mosi2;
    assign miso3 = miso_tied ? 1'b1 : mosi3;

    spi_master_txn_ctrl #(.NO_OF_SLAVES(2), .CLK_DIV(H), .MAX_BITS(32)) dut (
        .pclk(pclk), .areset(areset), .start(start), .slave_sel(slave_sel),
        .cpol(cpol), .cpha(cpha), .lanes(lanes), .num_bits(num_bits), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .cs(cs),
        .mosi0(mosi0), .mosi1(mosi1), .mosi2(mosi2), .mosi3(mosi3),
        .miso0(miso0), .miso1(miso1), .miso2(miso2), .miso3(miso3)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [1:0] ln, input logic [5:0] nb,
                                   input logic [31:0] tx, input bit tied);
        exp_t        e;
        int          n;
        int          l;
        int          b;
        logic [31:0] m;
        n = (nb == 6'd0 || nb > 6'd32) ? 32 : int'(nb);
        l = (ln == 2'b01) ? 2 : (ln == 2'b10) ? 4 : 1;
        b = (n + l - 1) / l;
        m = 32'h0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        e.rx  = tied ? m : (tx & m);
        e.lat = 2 * H * (b + 1) + 1;
        return e;
    endfunction

    task automatic start_txn(input logic sel, input logic p, input logic h, input logic [1:0] ln,
                             input logic [5:0] nb, input logic [31:0] tx, input bit tied, input bit push);
        @(posedge pclk); #1;
        slave_sel = sel; cpol = p; cpha = h; lanes = ln; num_bits = nb; tx_data = tx;
        miso_tied = tied; start = 1'b1;
        if (push) sb_q.push_back(model(ln, nb, tx, tied));
        @(posedge pclk); #1;
        start = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(output bit ok, output int lat, output int rises, output logic [3:0] mosi_rise);
        logic prev;
        ok = 1'b0; lat = 0; rises = 0; mosi_rise = 4'h0;
        prev = sclk;
        for (int i = 0; i < 400; i++) begin
            @(posedge pclk); #1;
            if (sclk && !prev) begin
                rises++;
                mosi_rise = {mosi3, mosi2, mosi1, mosi0};
            end
            prev = sclk;
            if (done) begin
                ok  = 1'b1;
                lat = cyc - accept_cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b0; start = 1'b0; slave_sel = 1'b0; cpol = 1'b0; cpha = 1'b0;
        lanes = 2'b00; num_bits = 6'd8; tx_data = 32'h0; miso_tied = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({busy, done, sclk, cs, mosi3, mosi2, mosi1, mosi0} !== 9'b000110000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/sclk/cs/mosi=%b expected 000110000",
                     {busy, done, sclk, cs, mosi3, mosi2, mosi1, mosi0});
        end
        checks++;
        if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx: got %h expected 0", rx_data); end
        areset = 1'b1;
    endtask

    task automatic test_single();
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e;
        start_txn(1'b0, 1'b0, 1'b0, 2'b00, 6'd8, 32'hA5, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1 || cs !== 2'b10) begin
            errors++; $display("FAIL single_accept: busy=%b cs=%b expected 1 10", busy, cs);
        end
        wait_done(ok, lat, rises, mr);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: no done within budget"); end
        checks++;
        if (rx_data !== e.rx || lat !== e.lat) begin
            errors++; $display("FAIL single_rx: rx=%h lat=%0d expected %h %0d", rx_data, lat, e.rx, e.lat);
        end
        checks++;
        if (rises !== 8 || busy !== 1'b0 || cs !== 2'b11) begin
            errors++; $display("FAIL single_edges: rises=%0d busy=%b cs=%b expected 8 0 11", rises, busy, cs);
        end
    endtask

    task automatic test_quad();
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e;
        start_txn(1'b0, 1'b1, 1'b1, 2'b10, 6'd32, 32'h12345678, 1'b0, 1'b1);
        wait_done(ok, lat, rises, mr);
        e = sb_q.pop_front();
        checks++;
        if (!ok || rx_data !== e.rx || lat !== e.lat) begin
            errors++; $display("FAIL quad_rx: ok=%b rx=%h lat=%0d expected %h %0d", ok, rx_data, lat, e.rx, e.lat);
        end
        checks++;
        if (rises !== 8 || sclk !== 1'b1) begin
            errors++; $display("FAIL quad_sclk: rises=%0d sclk=%b expected 8 1", rises, sclk);
        end
    endtask

    task automatic test_dual_short();
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e;
        start_txn(1'b0, 1'b0, 1'b0, 2'b01, 6'd5, 32'h1B, 1'b1, 1'b1);
        wait_done(ok, lat, rises, mr);
        e = sb_q.pop_front();
        checks++;
        if (!ok || rx_data !== e.rx || lat !== e.lat) begin
            errors++; $display("FAIL dual_rx: ok=%b rx=%h lat=%0d expected %h %0d", ok, rx_data, lat, e.rx, e.lat);
        end
        checks++;
        if (rises !== 3 || mr !== 4'b0010) begin
            errors++; $display("FAIL dual_last_beat: rises=%0d mosi=%b expected 3 0010", rises, mr);
        end
    endtask

    task automatic test_modes();
        mode_t tbl[3];
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e;
        tbl[0] = '{1'b1, 1'b0, 2'b01, 6'd16, 32'h0000BEEF};
        tbl[1] = '{1'b0, 1'b1, 2'b10, 6'd12, 32'h0000FABC};
        tbl[2] = '{1'b1, 1'b1, 2'b11, 6'd7,  32'h000000D5};
        for (int i = 0; i < 3; i++) begin
            start_txn(1'b0, tbl[i].p, tbl[i].h, tbl[i].ln, tbl[i].nb, tbl[i].tx, 1'b0, 1'b1);
            wait_done(ok, lat, rises, mr);
            e = sb_q.pop_front();
            checks++;
            if (!ok || rx_data !== e.rx || lat !== e.lat) begin
                errors++;
                $display("FAIL mode%0d: ok=%b rx=%h lat=%0d expected %h %0d", i, ok, rx_data, lat, e.rx, e.lat);
            end
        end
    endtask

    task automatic test_clamp();
        logic [5:0] nbs[2];
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e; logic [31:0] tx;
        nbs[0] = 6'd0;
        nbs[1] = 6'd40;
        for (int i = 0; i < 2; i++) begin
            tx = $urandom;
            start_txn(1'b0, 1'b0, 1'b0, 2'b10, nbs[i], tx, 1'b0, 1'b1);
            wait_done(ok, lat, rises, mr);
            e = sb_q.pop_front();
            checks++;
            if (!ok || rx_data !== e.rx || lat !== e.lat) begin
                errors++;
                $display("FAIL clamp%0d: ok=%b rx=%h lat=%0d expected %h %0d", i, ok, rx_data, lat, e.rx, e.lat);
            end
        end
    endtask

    task automatic test_midstart_sel();
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e; int extra;
        start_txn(1'b1, 1'b0, 1'b1, 2'b00, 6'd4, 32'h9, 1'b0, 1'b1);
        checks++;
        if (cs !== 2'b01) begin errors++; $display("FAIL sel1_cs: got %b expected 01", cs); end
        repeat (4) @(posedge pclk);
        #1;
        slave_sel = 1'b0; num_bits = 6'd8; tx_data = 32'hFF; start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        checks++;
        if (cs !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL midstart_cs: cs=%b busy=%b expected 01 1", cs, busy);
        end
        wait_done(ok, lat, rises, mr);
        e = sb_q.pop_front();
        checks++;
        if (!ok || rx_data !== e.rx || lat !== e.lat) begin
            errors++; $display("FAIL midstart_rx: ok=%b rx=%h lat=%0d expected %h %0d", ok, rx_data, lat, e.rx, e.lat);
        end
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge pclk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL midstart_queued: %0d busy/done cycles expected 0", extra); end
    endtask

    task automatic test_abort();
        int rises; logic prev; int extra;
        start_txn(1'b0, 1'b0, 1'b0, 2'b00, 6'd8, 32'hC3, 1'b0, 1'b0);
        rises = 0;
        prev = sclk;
        for (int i = 0; i < 100 && rises < 4; i++) begin
            @(posedge pclk); #1;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        checks++;
        if (rises !== 4) begin errors++; $display("FAIL abort_reach: rises=%0d expected 4", rises); end
        #1;
        areset = 1'b0;
        #1;
        checks++;
        if ({busy, done, sclk, cs, mosi3, mosi2, mosi1, mosi0} !== 9'b000110000 || rx_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: busy/done/sclk/cs/mosi=%b rx=%h expected 000110000 0",
                     {busy, done, sclk, cs, mosi3, mosi2, mosi1, mosi0}, rx_data);
        end
        @(posedge pclk); #1;
        areset = 1'b1;
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge pclk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0 || rx_data !== 32'h0) begin
            errors++; $display("FAIL abort_nodone: %0d busy/done cycles rx=%h expected 0 0", extra, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; int rises; logic [3:0] mr; exp_t e;
        @(posedge pclk); #1;
        slave_sel = 1'b0; cpol = 1'b0; cpha = 1'b0; lanes = 2'b01; num_bits = 6'd8;
        tx_data = 32'h3C; miso_tied = 1'b0; start = 1'b1;
        sb_q.push_back(model(2'b01, 6'd8, 32'h3C, 1'b0));
        @(posedge pclk); #1;
        accept_cyc = cyc;
        tx_data = 32'h96;
        sb_q.push_back(model(2'b01, 6'd8, 32'h96, 1'b0));
        wait_done(ok, lat, rises, mr);
        e = sb_q.pop_front();
        checks++;
        if (!ok || rx_data !== e.rx || lat !== e.lat) begin
            errors++; $display("FAIL b2b_first: ok=%b rx=%h lat=%0d expected %h %0d", ok, rx_data, lat, e.rx, e.lat);
        end
        @(posedge pclk); #1;
        checks++;
        if (busy !== 1'b0 || cs !== 2'b11) begin
            errors++; $display("FAIL b2b_gap: busy=%b cs=%b expected 0 11", busy, cs);
        end
        @(posedge pclk); #1;
        start = 1'b0;
        accept_cyc = cyc;
        checks++;
        if (busy !== 1'b1 || cs !== 2'b10) begin
            errors++; $display("FAIL b2b_accept: busy=%b cs=%b expected 1 10", busy, cs);
        end
        wait_done(ok, lat, rises, mr);
        e = sb_q.pop_front();
        checks++;
        if (!ok || rx_data !== e.rx || lat !== e.lat) begin
            errors++; $display("FAIL b2b_second: ok=%b rx=%h lat=%0d expected %h %0d", ok, rx_data, lat, e.rx, e.lat);
        end
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left: %0d entries expected 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_quad();
        test_dual_short();
        test_modes();
        test_clamp();
        test_midstart_sel();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
